// File: rtl/rv32i_types.sv
// Shared RV32I types for the data-memory path.
// Holds the sequencer state encoding and the funct3 access-width codes.
// Ports: none (package).
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // funct3[1:0] access width; 2'b11 is not a legal RV32I width and is
  // handled as a word.
  localparam logic [1:0] F3_BYTE = 2'b00;
  localparam logic [1:0] F3_HALF = 2'b01;
  localparam logic [1:0] F3_WORD = 2'b10;

endpackage

// File: rtl/dmem_sequencer_if.sv
// Bundle between the mem stage, the data memory and dmem_sequencer.
// Ports: request (req_*), memory bus (dmem_*), pipeline control (stall) and
// response (rsp_*). misaligned exists only with DMEM_MISALIGN_TRAP_EN.
interface dmem_sequencer_if;
  logic        req_valid;
  logic        req_is_load;
  logic        req_is_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;

  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_rmask;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misaligned;

  modport master (
    output req_valid, req_is_load, req_is_store, req_addr, req_wdata, req_funct3,
    output dmem_rdata, dmem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  stall, rsp_valid, rsp_rdata, rsp_rmask, misaligned
  );

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_addr, req_wdata, req_funct3,
    input  dmem_rdata, dmem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output stall, rsp_valid, rsp_rdata, rsp_rmask, misaligned
  );
`else
  modport master (
    output req_valid, req_is_load, req_is_store, req_addr, req_wdata, req_funct3,
    output dmem_rdata, dmem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  stall, rsp_valid, rsp_rdata, rsp_rmask
  );

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_addr, req_wdata, req_funct3,
    input  dmem_rdata, dmem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output stall, rsp_valid, rsp_rdata, rsp_rmask
  );
`endif
endinterface

// File: rtl/dmem_lane_gen.sv
// Combinational byte-lane mask and store-data shifter for one access.
// Ports: width/offset/wdata/is_load/is_store in; rmask, wmask and the
// lane-shifted wdata_lane out. Word and halfword ignore the low offset bits.
module dmem_lane_gen
  import rv32i_types::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic        is_load,
  input  logic        is_store,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane
);

  logic [3:0] lanes;

  always_comb begin
    lanes      = 4'b1111;
    wdata_lane = wdata;
    case (width)
      F3_BYTE: begin
        lanes      = 4'b0001 << offset;
        wdata_lane = {24'b0, wdata[7:0]} << {offset, 3'b000};
      end
      F3_HALF: begin
        lanes      = 4'b0011 << {offset[1], 1'b0};
        wdata_lane = {16'b0, wdata[15:0]} << {offset[1], 4'b0000};
      end
      default: begin
        lanes      = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  // A load never enables write lanes, even if both type bits are set.
  assign rmask = is_load ? lanes : 4'b0000;
  assign wmask = (is_store && !is_load) ? lanes : 4'b0000;

endmodule

// File: rtl/dmem_sequencer.sv
// Data-memory access sequencer: IDLE -> BUSY (wait dmem_resp) -> DONE.
// Ports: clk, rst (sync, active-high), bus (dmem_sequencer_if.slave).
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip BUSY and trap in DONE.
module dmem_sequencer
  import rv32i_types::*;
(
  input  logic             clk,
  input  logic             rst,
  dmem_sequencer_if.slave  bus
);

  dmem_state_t state, state_n;

  logic        accept;
  logic        mis_req;
  logic [3:0]  gen_rmask, gen_wmask;
  logic [31:0] gen_wdata;

  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  rmask_q, wmask_q, rsp_rmask_q;

  logic        stall_c, rsp_valid_c;
  logic [3:0]  rmask_c, wmask_c;

  // Signedness (funct3[2]) is applied by the writeback aligner, not here.
  logic unused_signedness;
  assign unused_signedness = bus.req_funct3[2];

  assign accept = bus.req_valid && (bus.req_is_load || bus.req_is_store);

  dmem_lane_gen u_lane_gen (
    .width      (bus.req_funct3[1:0]),
    .offset     (bus.req_addr[1:0]),
    .wdata      (bus.req_wdata),
    .is_load    (bus.req_is_load),
    .is_store   (bus.req_is_store),
    .rmask      (gen_rmask),
    .wmask      (gen_wmask),
    .wdata_lane (gen_wdata)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    mis_req = 1'b0;
    case (bus.req_funct3[1:0])
      F3_BYTE: mis_req = 1'b0;
      F3_HALF: mis_req = bus.req_addr[0];
      default: mis_req = (bus.req_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign mis_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Access capture: request fields latch on accept, read data on dmem_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= 32'b0;
      wdata_q     <= 32'b0;
      rmask_q     <= 4'b0;
      wmask_q     <= 4'b0;
      rdata_q     <= 32'b0;
      rsp_rmask_q <= 4'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= {bus.req_addr[31:2], 2'b00};
            wdata_q <= gen_wdata;
            rmask_q <= mis_req ? 4'b0 : gen_rmask;
            wmask_q <= mis_req ? 4'b0 : gen_wmask;
            // A trapped access reports no lanes read.
            if (mis_req) rsp_rmask_q <= 4'b0;
          end
        end
        BUSY: begin
          if (bus.dmem_resp) begin
            rdata_q     <= bus.dmem_rdata;
            rsp_rmask_q <= rmask_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    stall_c     = 1'b0;
    rsp_valid_c = 1'b0;
    rmask_c     = 4'b0;
    wmask_c     = 4'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_c = 1'b1;
          state_n = mis_req ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        rmask_c = rmask_q;
        wmask_c = wmask_q;
        if (bus.dmem_resp) state_n = DONE;
      end
      DONE: begin
        rsp_valid_c = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Reset wins over an in-flight access and over a simultaneous request.
    if (rst) begin
      state_n     = IDLE;
      stall_c     = 1'b0;
      rsp_valid_c = 1'b0;
      rmask_c     = 4'b0;
      wmask_c     = 4'b0;
    end
  end

  assign bus.stall      = stall_c;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.dmem_rmask = rmask_c;
  assign bus.dmem_wmask = wmask_c;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_rmask  = rsp_rmask_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;

  always_ff @(posedge clk) begin
    if (rst)                        mis_q <= 1'b0;
    else if (state == IDLE && accept) mis_q <= mis_req;
  end

  assign bus.misaligned = mis_q && (state == DONE) && !rst;
`endif

endmodule

// File: doc/dmem_sequencer.md
DMEM_SEQUENCER -- requirements
Module: dmem_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port req_valid, input, 1: the mem stage presents an access this cycle.
REQ-004 SHALL have port req_is_load / req_is_store, input, 1 each: access type; both 0 means no access.
REQ-005 SHALL have port req_addr, input, 32: byte address.
REQ-006 SHALL have port req_wdata, input, 32: unshifted store data (rs2).
REQ-007 SHALL have port req_funct3, input, 3: RV32I width and signedness encoding.
REQ-008 SHALL have port dmem_addr, output, 32: word-aligned address {req_addr[31:2],2'b00}.
REQ-009 SHALL have ports dmem_rmask / dmem_wmask, output, 4 each: byte-lane enables.
REQ-010 SHALL have port dmem_wdata, output, 32: lane-shifted store data.
REQ-011 SHALL have ports dmem_rdata (input, 32) and dmem_resp (input, 1): memory read data and completion strobe.
REQ-012 SHALL have port stall, output, 1: freeze all pipeline registers upstream of mem_wb.
REQ-013 SHALL have port rsp_valid, output, 1: access complete this cycle.
REQ-014 SHALL have port rsp_rdata, output, 32: captured raw word, passed to the mem_wb register unaligned.
REQ-015 SHALL have port rsp_rmask, output, 4: lanes that were read, for the writeback aligner and RVFI.
REQ-016 SHALL have port misaligned, output, 1: a trap is signalled (exists only with the macro in REQ-036).

Function
REQ-017 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-018 In IDLE, the access SHALL be accepted when req_valid && (req_is_load||req_is_store): latch addr, masks and wdata; go to BUSY.
REQ-019 In BUSY, dmem_addr, the masks and dmem_wdata SHALL be held stable until dmem_resp.
REQ-020 In BUSY with dmem_resp=1, the block SHALL capture dmem_rdata into rsp_rdata and go to DONE; the minimum accept-to-DONE time is 2 cycles.
REQ-021 In DONE, rsp_valid SHALL be 1 for exactly one cycle, stall=0 and masks=0; next state IDLE.
REQ-022 stall SHALL = (IDLE && accept condition) || BUSY; it SHALL be combinational in IDLE.
REQ-023 Outside BUSY, dmem_rmask and dmem_wmask SHALL both be 0.
REQ-024 In DONE and IDLE, rsp_rdata SHALL hold its last captured value.
REQ-025 Masks for byte accesses (funct3[1:0]=00) SHALL be 4'b0001<<addr[1:0].
REQ-026 Masks for halfword accesses (01) SHALL be 4'b0011<<{addr[1],1'b0}.
REQ-027 Masks for word accesses (10) SHALL be 4'b1111.
REQ-028 A load SHALL drive only rmask; a store SHALL drive only wmask.
REQ-029 For sb, dmem_wdata SHALL be wdata[7:0]<<(8*addr[1:0]); for sh, wdata[15:0]<<(16*addr[1]); for sw, unchanged.
REQ-030 rsp_rmask SHALL equal the issued rmask for loads and 0 for stores.
REQ-031 dmem_resp outside BUSY SHALL be ignored, with no state change.
REQ-032 A request is taken only in IDLE; a new access SHALL never be issued in the DONE cycle.
REQ-033 funct3[1:0]=11 SHALL be treated as word width.

Reset
REQ-034 When rst=1, the next state SHALL be IDLE, and stall, rsp_valid, rsp_rdata, rsp_rmask, the masks, dmem_addr, dmem_wdata and misaligned SHALL all be 0.
REQ-035 Reset SHALL override an in-flight BUSY (the access is abandoned; a later dmem_resp is ignored) and SHALL override a simultaneous req_valid.

Configuration
REQ-036 With DMEM_MISALIGN_TRAP_EN defined, an access with half && addr[0], or word && addr[1:0]!=0, SHALL not be issued: go IDLE->DONE directly with masks 0, misaligned=1 and rsp_valid=1 in DONE.
REQ-037 Without DMEM_MISALIGN_TRAP_EN, the misaligned port SHALL be absent, the low address bits SHALL be ignored for width alignment (addr[1:0] forced 0 for word, addr[0] forced 0 for half), and every access SHALL be issued.

Structure
REQ-038 dmem_state_t (IDLE/BUSY/DONE) and the funct3 width constants SHALL live in rv32i_types.
REQ-039 The mask/shift generator SHALL be one combinational sub-module, dmem_lane_gen.

Verification
REQ-040 Scenario: lw at 0x1000_0008, resp after 3 cycles with rdata 0xDEADBEEF -> rmask 1111 held 3 cycles, stall=1 throughout, rsp_valid one cycle, rsp_rdata 0xDEADBEEF.
REQ-041 Scenario: sb at 0x...0003 with wdata 0x000000A5 -> wmask 1000, dmem_wdata 0xA5000000, rmask 0000.
REQ-042 Scenario: lh at 0x...0002, resp same cycle as issue -> rmask 1100, DONE on the 2nd cycle after accept.
REQ-043 Scenario: rst asserted in BUSY, dmem_resp one cycle later -> IDLE, no rsp_valid, outputs 0.
REQ-044 Scenario: stray dmem_resp while in IDLE -> no state or output change.
REQ-045 Scenario: with DMEM_MISALIGN_TRAP_EN, sw at 0x...0001 -> masks 0 always, misaligned=1 and rsp_valid=1 in the next cycle.
